// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO write/read pointer logic.
//   DEF_DATA_W / DEF_ADDR_W / DEF_CNT_W : default widths for the FIFO blocks
//   PTR_MAX_W                           : widest pointer the Gray helpers take
//   wr_flags_t                          : registered status flags of the write side
//   bin2gray / gray2bin                 : pointer code conversions
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 16;

    // The helpers work on a fixed wide vector; callers zero-extend their
    // pointer into it and keep the low bits of the result. Leading zeros
    // are neutral for both conversions.
    localparam int PTR_MAX_W = 32;

    typedef struct packed {
        logic overflow;
        logic almostFull;
    } wr_flags_t;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl_if
// Bundles the write-side control/status signals of the FIFO write controller.
//   master : the side that issues writes and supplies the synced read pointer
//   slave  : the write controller itself
// Signals: sw_rst, write_enable, wdata, afull_value, rptr_gray_sync, stat_clr
//          (master -> slave); mem_we, mem_waddr, mem_wdata, wptr_gray, wfull,
//          wr_almost_full, overflow, wr_level, peak_level, fifo_write_count
//          (slave -> master).
// ---------------------------------------------------------------------------
interface fifo_wr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
)();

    logic              sw_rst;
    logic              write_enable;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W:0]   afull_value;
    logic [ADDR_W:0]   rptr_gray_sync;
    logic              stat_clr;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W:0]   wptr_gray;
    logic              wfull;
    logic              wr_almost_full;
    logic              overflow;
    logic [ADDR_W:0]   wr_level;
    logic [ADDR_W:0]   peak_level;
    logic [CNT_W-1:0]  fifo_write_count;

    modport master (
        output sw_rst, write_enable, wdata, afull_value, rptr_gray_sync, stat_clr,
        input  mem_we, mem_waddr, mem_wdata, wptr_gray, wfull, wr_almost_full,
               overflow, wr_level, peak_level, fifo_write_count
    );

    modport slave (
        input  sw_rst, write_enable, wdata, afull_value, rptr_gray_sync, stat_clr,
        output mem_we, mem_waddr, mem_wdata, wptr_gray, wfull, wr_almost_full,
               overflow, wr_level, peak_level, fifo_write_count
    );

endinterface

// File: rtl/fifo_wptr_gray.sv
// ---------------------------------------------------------------------------
// fifo_wptr_gray
// Binary pointer register with Gray-coded registered copy and the
// "one lap ahead" compare against the peer pointer. Written generically so
// the read side can reuse it.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : synchronous clear of pointer and compare flag
//   incr_i       : advance the pointer by one
//   peerGray_i   : peer pointer in Gray code, already in this clock domain
//   addr_o       : memory address (pointer without the lap bit)
//   binNext_o    : pointer value being loaded this cycle
//   gray_o       : registered Gray pointer for the other domain
//   full_o       : registered "pointer is one full lap ahead of peer"
// ---------------------------------------------------------------------------
module fifo_wptr_gray
    import fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            incr_i,
    input  logic [ADDR_W:0] peerGray_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W:0] binNext_o,
    output logic [ADDR_W:0] gray_o,
    output logic            full_o
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0]        bin_q, bin_d;
    logic [PW-1:0]        gray_q, gray_d;
    logic                 full_q, full_d;
    logic [PW-1:0]        binInc;
    logic [PW-1:0]        grayInc;
    logic [PW-1:0]        peerLapped;
    logic [PTR_MAX_W-1:0] grayWide;
    logic [PTR_MAX_W-1:PW] unusedGrayHi;

    assign binInc       = bin_q + {{ADDR_W{1'b0}}, incr_i};
    assign grayWide     = bin2gray(PTR_MAX_W'(binInc));
    assign grayInc      = grayWide[PW-1:0];
    assign unusedGrayHi = grayWide[PTR_MAX_W-1:PW];

    // In Gray code, the peer pointer shifted by exactly one lap differs only
    // in its two top bits, so full is an equality test against that pattern.
    assign peerLapped = {~peerGray_i[ADDR_W:ADDR_W-1], peerGray_i[ADDR_W-2:0]};

    // Next-state selection: a clear wins over any increment.
    always_comb begin
        bin_d  = binInc;
        gray_d = grayInc;
        full_d = (grayInc == peerLapped);
        if (clear_i) begin
            bin_d  = '0;
            gray_d = '0;
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            full_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            full_q <= full_d;
        end
    end

    assign addr_o    = bin_q[ADDR_W-1:0];
    assign binNext_o = binInc;
    assign gray_o    = gray_q;
    assign full_o    = full_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of an asynchronous FIFO: accepts writes while not
// full, drives the memory write port, publishes the Gray write pointer and
// keeps level / almost-full / overflow / high-water / write-count status.
//   wclk      : write-domain clock
//   hw_rst_n  : asynchronous active-low hardware reset
//   bus       : fifo_wr_ctrl_if.slave (write request, memory port, status)
// The synced read pointer arrives already in the wclk domain; no
// synchronisers live here.
// ---------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
)(
    input  logic          wclk,
    input  logic          hw_rst_n,
    fifo_wr_ctrl_if.slave bus
);

    localparam int PW = ADDR_W + 1;

    logic                  accept;
    logic                  wfullInt;
    logic [ADDR_W-1:0]     waddr;
    logic [PW-1:0]         wbinNext;
    logic [PW-1:0]         wgray;
    logic [PW-1:0]         rbin;
    logic [PW-1:0]         levelNext;
    logic [PTR_MAX_W-1:0]  rbinWide;
    logic [PTR_MAX_W-1:PW] unusedRbinHi;
    logic [DATA_W-1:0]     wdataPass;

    wr_flags_t             flags_q, flags_d;
    logic [PW-1:0]         level_q, level_d;
    logic [PW-1:0]         peak_q, peak_d;
    logic [CNT_W-1:0]      count_q, count_d;

    assign accept = bus.write_enable & ~wfullInt & ~bus.sw_rst;

    fifo_wptr_gray #(
        .ADDR_W (ADDR_W)
    ) u_wptr (
        .clk        (wclk),
        .rst_n      (hw_rst_n),
        .clear_i    (bus.sw_rst),
        .incr_i     (accept),
        .peerGray_i (bus.rptr_gray_sync),
        .addr_o     (waddr),
        .binNext_o  (wbinNext),
        .gray_o     (wgray),
        .full_o     (wfullInt)
    );

    assign rbinWide     = gray2bin(PTR_MAX_W'(bus.rptr_gray_sync));
    assign rbin         = rbinWide[PW-1:0];
    assign unusedRbinHi = rbinWide[PTR_MAX_W-1:PW];

    // Modular difference; overestimates while the synced read pointer lags.
    assign levelNext = wbinNext - rbin;

    // The memory strobe is gated by reset too: wfull reads 0 during reset,
    // so a pending request would otherwise leak through.
    assign wdataPass     = bus.wdata;
    assign bus.mem_we    = accept & hw_rst_n;
    assign bus.mem_waddr = waddr;
    assign bus.mem_wdata = wdataPass;

    // Status next-state. Overflow set beats stat_clr so a coincident event
    // is not lost; stat_clr reloads the high-water mark from the current
    // level rather than zero. sw_rst overrides everything.
    always_comb begin
        level_d             = levelNext;
        flags_d.almostFull  = (bus.afull_value != '0) && (levelNext >= bus.afull_value);
        flags_d.overflow    = flags_q.overflow;
        if (bus.write_enable && wfullInt) begin
            flags_d.overflow = 1'b1;
        end else if (bus.stat_clr) begin
            flags_d.overflow = 1'b0;
        end
        if (bus.stat_clr) begin
            peak_d = levelNext;
        end else if (levelNext > peak_q) begin
            peak_d = levelNext;
        end else begin
            peak_d = peak_q;
        end
        count_d = count_q;
        if (accept && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (bus.sw_rst) begin
            level_d = '0;
            flags_d = '0;
            peak_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge wclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            flags_q <= '0;
            level_q <= '0;
            peak_q  <= '0;
            count_q <= '0;
        end else begin
            flags_q <= flags_d;
            level_q <= level_d;
            peak_q  <= peak_d;
            count_q <= count_d;
        end
    end

    assign bus.wptr_gray        = wgray;
    assign bus.wfull            = wfullInt;
    assign bus.wr_almost_full   = flags_q.almostFull;
    assign bus.overflow         = flags_q.overflow;
    assign bus.wr_level         = level_q;
    assign bus.peak_level       = peak_q;
    assign bus.fifo_write_count = count_q;

endmodule
